// File: rtl/in_port.sv
// Ingress port: frames 1024-bit beats into packets, truncates long packets,
// and buffers them in a 2-entry FIFO that presents one PHV byte per output.
module in_port #(
  parameter int MAX_BEATS = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1023:0] io_data,
  input  logic          io_last,
  input  logic          io_en,
  output logic          io_ready,
  output logic [7:0]    io_phv_out_data_0,   io_phv_out_data_1,   io_phv_out_data_2,   io_phv_out_data_3,
                        io_phv_out_data_4,   io_phv_out_data_5,   io_phv_out_data_6,   io_phv_out_data_7,
                        io_phv_out_data_8,   io_phv_out_data_9,   io_phv_out_data_10,  io_phv_out_data_11,
                        io_phv_out_data_12,  io_phv_out_data_13,  io_phv_out_data_14,  io_phv_out_data_15,
                        io_phv_out_data_16,  io_phv_out_data_17,  io_phv_out_data_18,  io_phv_out_data_19,
                        io_phv_out_data_20,  io_phv_out_data_21,  io_phv_out_data_22,  io_phv_out_data_23,
                        io_phv_out_data_24,  io_phv_out_data_25,  io_phv_out_data_26,  io_phv_out_data_27,
                        io_phv_out_data_28,  io_phv_out_data_29,  io_phv_out_data_30,  io_phv_out_data_31,
                        io_phv_out_data_32,  io_phv_out_data_33,  io_phv_out_data_34,  io_phv_out_data_35,
                        io_phv_out_data_36,  io_phv_out_data_37,  io_phv_out_data_38,  io_phv_out_data_39,
                        io_phv_out_data_40,  io_phv_out_data_41,  io_phv_out_data_42,  io_phv_out_data_43,
                        io_phv_out_data_44,  io_phv_out_data_45,  io_phv_out_data_46,  io_phv_out_data_47,
                        io_phv_out_data_48,  io_phv_out_data_49,  io_phv_out_data_50,  io_phv_out_data_51,
                        io_phv_out_data_52,  io_phv_out_data_53,  io_phv_out_data_54,  io_phv_out_data_55,
                        io_phv_out_data_56,  io_phv_out_data_57,  io_phv_out_data_58,  io_phv_out_data_59,
                        io_phv_out_data_60,  io_phv_out_data_61,  io_phv_out_data_62,  io_phv_out_data_63,
                        io_phv_out_data_64,  io_phv_out_data_65,  io_phv_out_data_66,  io_phv_out_data_67,
                        io_phv_out_data_68,  io_phv_out_data_69,  io_phv_out_data_70,  io_phv_out_data_71,
                        io_phv_out_data_72,  io_phv_out_data_73,  io_phv_out_data_74,  io_phv_out_data_75,
                        io_phv_out_data_76,  io_phv_out_data_77,  io_phv_out_data_78,  io_phv_out_data_79,
                        io_phv_out_data_80,  io_phv_out_data_81,  io_phv_out_data_82,  io_phv_out_data_83,
                        io_phv_out_data_84,  io_phv_out_data_85,  io_phv_out_data_86,  io_phv_out_data_87,
                        io_phv_out_data_88,  io_phv_out_data_89,  io_phv_out_data_90,  io_phv_out_data_91,
                        io_phv_out_data_92,  io_phv_out_data_93,  io_phv_out_data_94,  io_phv_out_data_95,
                        io_phv_out_data_96,  io_phv_out_data_97,  io_phv_out_data_98,  io_phv_out_data_99,
                        io_phv_out_data_100, io_phv_out_data_101, io_phv_out_data_102, io_phv_out_data_103,
                        io_phv_out_data_104, io_phv_out_data_105, io_phv_out_data_106, io_phv_out_data_107,
                        io_phv_out_data_108, io_phv_out_data_109, io_phv_out_data_110, io_phv_out_data_111,
                        io_phv_out_data_112, io_phv_out_data_113, io_phv_out_data_114, io_phv_out_data_115,
                        io_phv_out_data_116, io_phv_out_data_117, io_phv_out_data_118, io_phv_out_data_119,
                        io_phv_out_data_120, io_phv_out_data_121, io_phv_out_data_122, io_phv_out_data_123,
                        io_phv_out_data_124, io_phv_out_data_125, io_phv_out_data_126, io_phv_out_data_127,
  output logic          io_phv_out_valid,
  output logic          io_phv_out_last,
  output logic          io_phv_out_first,
  input  logic          io_phv_out_ready,
  output logic [31:0]   io_pkt_count,
  output logic [15:0]   io_trunc_count
);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t        state, state_next;
  logic [7:0]    bcnt, bcnt_next;
  logic [1023:0] mem_data [2];
  logic          mem_last [2];
  logic          mem_first [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    occ;
  logic          accept, push, pop, push_first, push_last, trunc;
  logic [1023:0] head_data;
  logic [7:0]    head_bytes [128];

  // Gating with reset keeps the port closed while reset is held low.
  assign io_ready         = reset && (occ < 2'd2);
  assign accept           = io_en && io_ready;
  assign io_phv_out_valid = (occ != 2'd0);
  assign pop              = io_phv_out_valid && io_phv_out_ready;

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    push       = 1'b0;
    push_first = 1'b0;
    push_last  = 1'b0;
    trunc      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          push       = 1'b1;
          push_first = 1'b1;
          if (io_last) begin
            push_last = 1'b1;
          end else begin
            bcnt_next  = 8'd1;
            state_next = BODY;
          end
        end
      end
      BODY: begin
        if (accept) begin
          push = 1'b1;
          if (io_last) begin
            push_last  = 1'b1;
            bcnt_next  = 8'd0;
            state_next = IDLE;
          end else if (bcnt + 8'd1 == 8'(MAX_BEATS)) begin
            push_last  = 1'b1;
            trunc      = 1'b1;
            bcnt_next  = 8'd0;
            state_next = DROP;
          end else begin
            bcnt_next = bcnt + 8'd1;
          end
        end
      end
      DROP: begin
        if (accept && io_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bcnt  <= 8'd0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr]  <= io_data;
      mem_last[wr_ptr]  <= push_last;
      mem_first[wr_ptr] <= push_first;
    end
  end

  always_comb begin
    head_data        = '0;
    io_phv_out_last  = 1'b0;
    io_phv_out_first = 1'b0;
    if (occ != 2'd0) begin
      head_data        = mem_data[rd_ptr];
      io_phv_out_last  = mem_last[rd_ptr];
      io_phv_out_first = mem_first[rd_ptr];
    end
  end

  always_comb begin
    for (int k = 0; k < 128; k++) begin
      head_bytes[k] = head_data[1023-8*k -: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_pkt_count   <= 32'd0;
      io_trunc_count <= 16'd0;
    end else begin
      if (pop && io_phv_out_last) io_pkt_count <= io_pkt_count + 32'd1;
      if (trunc && io_trunc_count != 16'hFFFF) io_trunc_count <= io_trunc_count + 16'd1;
    end
  end

  assign io_phv_out_data_0   = head_bytes[0],   io_phv_out_data_1   = head_bytes[1],   io_phv_out_data_2   = head_bytes[2],   io_phv_out_data_3   = head_bytes[3];
  assign io_phv_out_data_4   = head_bytes[4],   io_phv_out_data_5   = head_bytes[5],   io_phv_out_data_6   = head_bytes[6],   io_phv_out_data_7   = head_bytes[7];
  assign io_phv_out_data_8   = head_bytes[8],   io_phv_out_data_9   = head_bytes[9],   io_phv_out_data_10  = head_bytes[10],  io_phv_out_data_11  = head_bytes[11];
  assign io_phv_out_data_12  = head_bytes[12],  io_phv_out_data_13  = head_bytes[13],  io_phv_out_data_14  = head_bytes[14],  io_phv_out_data_15  = head_bytes[15];
  assign io_phv_out_data_16  = head_bytes[16],  io_phv_out_data_17  = head_bytes[17],  io_phv_out_data_18  = head_bytes[18],  io_phv_out_data_19  = head_bytes[19];
  assign io_phv_out_data_20  = head_bytes[20],  io_phv_out_data_21  = head_bytes[21],  io_phv_out_data_22  = head_bytes[22],  io_phv_out_data_23  = head_bytes[23];
  assign io_phv_out_data_24  = head_bytes[24],  io_phv_out_data_25  = head_bytes[25],  io_phv_out_data_26  = head_bytes[26],  io_phv_out_data_27  = head_bytes[27];
  assign io_phv_out_data_28  = head_bytes[28],  io_phv_out_data_29  = head_bytes[29],  io_phv_out_data_30  = head_bytes[30],  io_phv_out_data_31  = head_bytes[31];
  assign io_phv_out_data_32  = head_bytes[32],  io_phv_out_data_33  = head_bytes[33],  io_phv_out_data_34  = head_bytes[34],  io_phv_out_data_35  = head_bytes[35];
  assign io_phv_out_data_36  = head_bytes[36],  io_phv_out_data_37  = head_bytes[37],  io_phv_out_data_38  = head_bytes[38],  io_phv_out_data_39  = head_bytes[39];
  assign io_phv_out_data_40  = head_bytes[40],  io_phv_out_data_41  = head_bytes[41],  io_phv_out_data_42  = head_bytes[42],  io_phv_out_data_43  = head_bytes[43];
  assign io_phv_out_data_44  = head_bytes[44],  io_phv_out_data_45  = head_bytes[45],  io_phv_out_data_46  = head_bytes[46],  io_phv_out_data_47  = head_bytes[47];
  assign io_phv_out_data_48  = head_bytes[48],  io_phv_out_data_49  = head_bytes[49],  io_phv_out_data_50  = head_bytes[50],  io_phv_out_data_51  = head_bytes[51];
  assign io_phv_out_data_52  = head_bytes[52],  io_phv_out_data_53  = head_bytes[53],  io_phv_out_data_54  = head_bytes[54],  io_phv_out_data_55  = head_bytes[55];
  assign io_phv_out_data_56  = head_bytes[56],  io_phv_out_data_57  = head_bytes[57],  io_phv_out_data_58  = head_bytes[58],  io_phv_out_data_59  = head_bytes[59];
  assign io_phv_out_data_60  = head_bytes[60],  io_phv_out_data_61  = head_bytes[61],  io_phv_out_data_62  = head_bytes[62],  io_phv_out_data_63  = head_bytes[63];
  assign io_phv_out_data_64  = head_bytes[64],  io_phv_out_data_65  = head_bytes[65],  io_phv_out_data_66  = head_bytes[66],  io_phv_out_data_67  = head_bytes[67];
  assign io_phv_out_data_68  = head_bytes[68],  io_phv_out_data_69  = head_bytes[69],  io_phv_out_data_70  = head_bytes[70],  io_phv_out_data_71  = head_bytes[71];
  assign io_phv_out_data_72  = head_bytes[72],  io_phv_out_data_73  = head_bytes[73],  io_phv_out_data_74  = head_bytes[74],  io_phv_out_data_75  = head_bytes[75];
  assign io_phv_out_data_76  = head_bytes[76],  io_phv_out_data_77  = head_bytes[77],  io_phv_out_data_78  = head_bytes[78],  io_phv_out_data_79  = head_bytes[79];
  assign io_phv_out_data_80  = head_bytes[80],  io_phv_out_data_81  = head_bytes[81],  io_phv_out_data_82  = head_bytes[82],  io_phv_out_data_83  = head_bytes[83];
  assign io_phv_out_data_84  = head_bytes[84],  io_phv_out_data_85  = head_bytes[85],  io_phv_out_data_86  = head_bytes[86],  io_phv_out_data_87  = head_bytes[87];
  assign io_phv_out_data_88  = head_bytes[88],  io_phv_out_data_89  = head_bytes[89],  io_phv_out_data_90  = head_bytes[90],  io_phv_out_data_91  = head_bytes[91];
  assign io_phv_out_data_92  = head_bytes[92],  io_phv_out_data_93  = head_bytes[93],  io_phv_out_data_94  = head_bytes[94],  io_phv_out_data_95  = head_bytes[95];
  assign io_phv_out_data_96  = head_bytes[96],  io_phv_out_data_97  = head_bytes[97],  io_phv_out_data_98  = head_bytes[98],  io_phv_out_data_99  = head_bytes[99];
  assign io_phv_out_data_100 = head_bytes[100], io_phv_out_data_101 = head_bytes[101], io_phv_out_data_102 = head_bytes[102], io_phv_out_data_103 = head_bytes[103];
  assign io_phv_out_data_104 = head_bytes[104], io_phv_out_data_105 = head_bytes[105], io_phv_out_data_106 = head_bytes[106], io_phv_out_data_107 = head_bytes[107];
  assign io_phv_out_data_108 = head_bytes[108], io_phv_out_data_109 = head_bytes[109], io_phv_out_data_110 = head_bytes[110], io_phv_out_data_111 = head_bytes[111];
  assign io_phv_out_data_112 = head_bytes[112], io_phv_out_data_113 = head_bytes[113], io_phv_out_data_114 = head_bytes[114], io_phv_out_data_115 = head_bytes[115];
  assign io_phv_out_data_116 = head_bytes[116], io_phv_out_data_117 = head_bytes[117], io_phv_out_data_118 = head_bytes[118], io_phv_out_data_119 = head_bytes[119];
  assign io_phv_out_data_120 = head_bytes[120], io_phv_out_data_121 = head_bytes[121], io_phv_out_data_122 = head_bytes[122], io_phv_out_data_123 = head_bytes[123];
  assign io_phv_out_data_124 = head_bytes[124], io_phv_out_data_125 = head_bytes[125], io_phv_out_data_126 = head_bytes[126], io_phv_out_data_127 = head_bytes[127];

endmodule
